// File: rtl/reduce_tree_pipe.sv
// Pipelined N-input bit-reduction tree (AND / OR / XOR / NAND) built from
// 2-input gate levels, with a valid/ready handshake and full backpressure.
// The op travels with its data through every stage; NAND runs through the
// tree as AND and is inverted only on the way into the final register.
module reduce_tree_pipe #(
  parameter int N_IN        = 8,
  parameter int LVL_PER_STG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in_data,
  input  logic [1:0]      in_op,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_bit,
  output logic [1:0]      out_op,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int LVLS    = $clog2(N_IN);
  localparam int NUM_STG = (LVLS + LVL_PER_STG - 1) / LVL_PER_STG;
  localparam int PW      = 1 << LVLS;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // One gate level: bit i of the result combines bits 2i and 2i+1.
  // The upper half is unused after the level and is forced to zero.
  function automatic logic [PW-1:0] combine_level(input logic [PW-1:0] v,
                                                  input logic [1:0]    op);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < PW / 2; i++) begin
      case (op)
        OP_OR:   r[i] = v[2*i] | v[2*i+1];
        OP_XOR:  r[i] = v[2*i] ^ v[2*i+1];
        default: r[i] = v[2*i] & v[2*i+1];
      endcase
    end
    return r;
  endfunction

  // Apply tree levels lo..hi-1; levels past the tree depth are skipped, so
  // the last stage naturally ends up with fewer levels when needed.
  function automatic logic [PW-1:0] run_levels(input logic [PW-1:0] v,
                                               input logic [1:0]    op,
                                               input int            lo,
                                               input int            hi);
    logic [PW-1:0] r;
    r = v;
    for (int l = 0; l < LVLS; l++) begin
      if (l >= lo && l < hi) r = combine_level(r, op);
    end
    return r;
  endfunction

  logic [PW-1:0]      dreg   [NUM_STG];
  logic [1:0]         opreg  [NUM_STG];
  logic [NUM_STG-1:0] v;

  logic [PW-1:0]      padded;
  logic [PW-1:0]      nxt_d  [NUM_STG];
  logic [1:0]         src_op [NUM_STG];
  logic [NUM_STG-1:0] src_v;
  logic [NUM_STG-1:0] load;

  // Pad the operand up to a power of two with the identity of the op.
  always_comb begin
    padded = {PW{(in_op == OP_AND) || (in_op == OP_NAND)}};
    padded[N_IN-1:0] = in_data;
  end

  // Per-stage combinational slice of the tree feeding each stage register.
  always_comb begin
    src_v[0]  = in_valid;
    src_op[0] = in_op;
    nxt_d[0]  = run_levels(padded, in_op, 0, LVL_PER_STG);
    for (int s = 1; s < NUM_STG; s++) begin
      src_v[s]  = v[s-1];
      src_op[s] = opreg[s-1];
      nxt_d[s]  = run_levels(dreg[s-1], opreg[s-1], s * LVL_PER_STG,
                             (s + 1) * LVL_PER_STG);
    end
    if (src_op[NUM_STG-1] == OP_NAND) nxt_d[NUM_STG-1][0] = ~nxt_d[NUM_STG-1][0];
  end

  // A stage may load when it, or any stage below it, is empty, or the
  // output is draining; this lets bubbles compress during a stall.
  always_comb begin
    logic tail_full;
    for (int s = 0; s < NUM_STG; s++) begin
      tail_full = 1'b1;
      for (int k = 0; k < NUM_STG; k++) begin
        if (k >= s) tail_full = tail_full & v[k];
      end
      load[s] = out_ready | ~tail_full;
    end
  end

  // Stage registers: valid always follows its source on load; data and op
  // are only captured for real items, so bubbles leave stale data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int s = 0; s < NUM_STG; s++) begin
        dreg[s]  <= '0;
        opreg[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_STG; s++) begin
        if (load[s]) begin
          v[s] <= src_v[s];
          if (src_v[s]) begin
            dreg[s]  <= nxt_d[s];
            opreg[s] <= src_op[s];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[NUM_STG-1];
  assign out_bit   = dreg[NUM_STG-1][0];
  assign out_op    = opreg[NUM_STG-1];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed and scoreboarded checks of reduce_tree_pipe with an 8-input and
// a 5-input instance sharing clock and reset.
module tb_reduce_tree_pipe;

  localparam int STG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_data;
  logic [1:0] a_op;
  logic       a_valid, a_ready, a_bit, a_ovalid, a_oready;
  logic [1:0] a_oop;
  logic [4:0] b_data;
  logic [1:0] b_op;
  logic       b_valid, b_ready, b_bit, b_ovalid, b_oready;
  logic [1:0] b_oop;

  int nvec = 0;
  int nmis = 0;

  logic       exp_q[$];
  logic [1:0] expop_q[$];

  reduce_tree_pipe #(.N_IN(8), .LVL_PER_STG(1)) dut8 (
    .clk(clk), .rst(rst), .in_data(a_data), .in_op(a_op), .in_valid(a_valid),
    .in_ready(a_ready), .out_bit(a_bit), .out_op(a_oop), .out_valid(a_ovalid),
    .out_ready(a_oready));

  reduce_tree_pipe #(.N_IN(5), .LVL_PER_STG(1)) dut5 (
    .clk(clk), .rst(rst), .in_data(b_data), .in_op(b_op), .in_valid(b_valid),
    .in_ready(b_ready), .out_bit(b_bit), .out_op(b_oop), .out_valid(b_ovalid),
    .out_ready(b_oready));

  function automatic logic model8(input logic [7:0] d, input logic [1:0] op);
    case (op)
      2'b00:   return &d;
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return ~(&d);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset with in_valid held high, then latency of the first item.
  task automatic test_reset;
    int edges;
    rst = 1'b1; a_valid = 1'b1; a_data = 8'hA5; a_op = 2'b01; a_oready = 1'b1;
    b_valid = 1'b0; b_data = '0; b_op = '0; b_oready = 1'b1;
    tick; tick;
    nvec++; if (a_ovalid !== 1'b0) begin nmis++; $display("[TB] FAIL reset_out_valid got=%b exp=0", a_ovalid); end
    nvec++; if (a_bit !== 1'b0) begin nmis++; $display("[TB] FAIL reset_out_bit got=%b exp=0", a_bit); end
    nvec++; if (a_oop !== 2'b00) begin nmis++; $display("[TB] FAIL reset_out_op got=%0d exp=0", a_oop); end
    nvec++; if (b_ovalid !== 1'b0) begin nmis++; $display("[TB] FAIL reset5_out_valid got=%b exp=0", b_ovalid); end
    rst = 1'b0; a_data = 8'hFF; a_op = 2'b00;
    #1;
    nvec++; if (a_ready !== 1'b1) begin nmis++; $display("[TB] FAIL reset_in_ready got=%b exp=1", a_ready); end
    tick;
    a_valid = 1'b0;
    edges = 0;
    while (a_ovalid !== 1'b1 && edges < 8) begin tick; edges++; end
    nvec++; if (edges != STG - 1) begin nmis++; $display("[TB] FAIL first_latency got=%0d exp=%0d", edges, STG - 1); end
    nvec++; if (a_bit !== 1'b1) begin nmis++; $display("[TB] FAIL first_bit got=%b exp=1", a_bit); end
    tick;
    nvec++; if (a_ovalid !== 1'b0) begin nmis++; $display("[TB] FAIL first_drain got=%b exp=0", a_ovalid); end
  endtask

  // Single items through the 8-input instance for every op.
  task automatic test_ops;
    logic [7:0] td[8] = '{8'hFF, 8'hFE, 8'h00, 8'h10, 8'h07, 8'hFF, 8'h7F, 8'h03};
    logic [1:0] to[8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    logic       te[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int n;
    a_oready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_data = td[i]; a_op = to[i]; a_valid = 1'b1;
      tick;
      a_valid = 1'b0;
      n = 0;
      while (a_ovalid !== 1'b1 && n < 8) begin tick; n++; end
      nvec++;
      if (a_ovalid !== 1'b1) begin
        nmis++; $display("[TB] FAIL ops_timeout vec=%0d got=%b exp=1", i, a_ovalid);
      end else begin
        if (a_bit !== te[i]) begin nmis++; $display("[TB] FAIL ops_bit vec=%0d data=%h op=%0d got=%b exp=%b", i, td[i], to[i], a_bit, te[i]); end
        nvec++;
        if (a_oop !== to[i]) begin nmis++; $display("[TB] FAIL ops_op vec=%0d got=%0d exp=%0d", i, a_oop, to[i]); end
      end
      tick;
    end
  endtask

  // Padding on the 5-input instance: bits 5..7 must take the op identity.
  task automatic test_padding;
    logic [4:0] td[4] = '{5'h1F, 5'h1F, 5'h00, 5'h00};
    logic [1:0] to[4] = '{2'd0, 2'd2, 2'd3, 2'd1};
    logic       te[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int n;
    b_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_data = td[i]; b_op = to[i]; b_valid = 1'b1;
      tick;
      b_valid = 1'b0;
      n = 0;
      while (b_ovalid !== 1'b1 && n < 8) begin tick; n++; end
      nvec++;
      if (b_ovalid !== 1'b1) begin
        nmis++; $display("[TB] FAIL pad_timeout vec=%0d got=%b exp=1", i, b_ovalid);
      end else if (b_bit !== te[i]) begin
        nmis++; $display("[TB] FAIL pad_bit vec=%0d data=%h op=%0d got=%b exp=%b", i, td[i], to[i], b_bit, te[i]);
      end
      tick;
    end
  endtask

  // 16 back-to-back random items with out_ready held high.
  task automatic test_back_to_back;
    int sent, got, gaps;
    exp_q = {}; expop_q = {};
    sent = 0; got = 0; gaps = 0;
    a_oready = 1'b1;
    for (int c = 0; c < 60 && got < 16; c++) begin
      if (sent < 16) begin
        a_valid = 1'b1; a_data = 8'($urandom); a_op = 2'($urandom_range(0, 3));
      end else a_valid = 1'b0;
      #1;
      if (a_ovalid && a_oready) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++; $display("[TB] FAIL b2b_extra got=%b exp=none", a_bit);
        end else begin
          if (a_bit !== exp_q[0] || a_oop !== expop_q[0]) begin
            nmis++; $display("[TB] FAIL b2b_item idx=%0d got=%b/%0d exp=%b/%0d", got, a_bit, a_oop, exp_q[0], expop_q[0]);
          end
          void'(exp_q.pop_front()); void'(expop_q.pop_front());
        end
        got++;
      end else if (got > 0 && got < 16) gaps++;
      if (a_valid && a_ready) begin
        exp_q.push_back(model8(a_data, a_op)); expop_q.push_back(a_op); sent++;
      end
      tick;
    end
    a_valid = 1'b0;
    nvec++; if (got != 16) begin nmis++; $display("[TB] FAIL b2b_count got=%0d exp=16", got); end
    nvec++; if (gaps != 0) begin nmis++; $display("[TB] FAIL b2b_gaps got=%0d exp=0", gaps); end
  endtask

  // Stall for 5 cycles with a full pipe, release, then random toggling.
  task automatic test_backpressure;
    int acc, got, total;
    exp_q = {}; expop_q = {};
    acc = 0; got = 0;
    a_oready = 1'b0;
    a_valid = 1'b1; a_data = 8'($urandom); a_op = 2'($urandom_range(0, 3));
    for (int c = 0; c < 10 && acc < STG; c++) begin
      #1;
      if (a_ready) begin
        exp_q.push_back(model8(a_data, a_op)); expop_q.push_back(a_op); acc++;
      end
      tick;
      if (a_ready === 1'b0 || acc < STG) begin
        a_data = 8'($urandom); a_op = 2'($urandom_range(0, 3));
      end
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      nvec++; if (a_ready !== 1'b0) begin nmis++; $display("[TB] FAIL stall_in_ready cyc=%0d got=%b exp=0", c, a_ready); end
      nvec++;
      if (a_ovalid !== 1'b1 || a_bit !== exp_q[0] || a_oop !== expop_q[0]) begin
        nmis++; $display("[TB] FAIL stall_hold cyc=%0d got=%b/%b/%0d exp=1/%b/%0d", c, a_ovalid, a_bit, a_oop, exp_q[0], expop_q[0]);
      end
      tick;
    end
    a_oready = 1'b1;
    #1;
    nvec++; if (a_ready !== 1'b1) begin nmis++; $display("[TB] FAIL release_in_ready got=%b exp=1", a_ready); end
    total = STG + 5;
    for (int c = 0; c < 40 && got < total; c++) begin
      a_valid = (acc < total);
      #1;
      if (a_ovalid && a_oready) begin
        nvec++;
        if (exp_q.size() == 0 || a_bit !== exp_q[0] || a_oop !== expop_q[0]) begin
          nmis++; $display("[TB] FAIL release_item idx=%0d got=%b/%0d", got, a_bit, a_oop);
        end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(expop_q.pop_front()); end
        got++;
      end
      if (a_valid && a_ready) begin
        exp_q.push_back(model8(a_data, a_op)); expop_q.push_back(a_op); acc++;
        tick;
        a_data = 8'($urandom); a_op = 2'($urandom_range(0, 3));
      end else tick;
    end
    a_valid = 1'b0;
    nvec++; if (got != total || exp_q.size() != 0) begin nmis++; $display("[TB] FAIL release_count got=%0d exp=%0d left=%0d", got, total, exp_q.size()); end

    acc = 0; got = 0; exp_q = {}; expop_q = {};
    for (int c = 0; c < 300 && got < 12; c++) begin
      a_valid  = (acc < 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      a_oready = 1'($urandom_range(0, 1));
      #1;
      if (a_ovalid && a_oready) begin
        nvec++;
        if (exp_q.size() == 0 || a_bit !== exp_q[0] || a_oop !== expop_q[0]) begin
          nmis++; $display("[TB] FAIL toggle_item idx=%0d got=%b/%0d", got, a_bit, a_oop);
        end
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(expop_q.pop_front()); end
        got++;
      end
      if (a_valid && a_ready) begin
        exp_q.push_back(model8(a_data, a_op)); expop_q.push_back(a_op); acc++;
        tick;
        a_data = 8'($urandom); a_op = 2'($urandom_range(0, 3));
      end else tick;
    end
    a_valid = 1'b0; a_oready = 1'b1;
    nvec++; if (got != 12 || exp_q.size() != 0) begin nmis++; $display("[TB] FAIL toggle_count got=%0d exp=12 left=%0d", got, exp_q.size()); end
  endtask

  // Reset with three items in flight; none of them may ever appear.
  task automatic test_reset_midstream;
    int acc, seen, n;
    acc = 0; seen = 0;
    a_oready = 1'b0;
    a_valid = 1'b1; a_data = 8'hFF; a_op = 2'b00;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      #1;
      if (a_ready) acc++;
      tick;
    end
    a_valid = 1'b0; rst = 1'b1;
    tick;
    nvec++; if (a_ovalid !== 1'b0) begin nmis++; $display("[TB] FAIL midrst_out_valid got=%b exp=0", a_ovalid); end
    nvec++; if (a_ready !== 1'b1) begin nmis++; $display("[TB] FAIL midrst_in_ready got=%b exp=1", a_ready); end
    rst = 1'b0; a_oready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (a_ovalid) seen++;
      tick;
    end
    nvec++; if (seen != 0) begin nmis++; $display("[TB] FAIL midrst_ghosts got=%0d exp=0", seen); end
    a_data = 8'h80; a_op = 2'b01; a_valid = 1'b1;
    tick;
    a_valid = 1'b0;
    n = 0;
    while (a_ovalid !== 1'b1 && n < 8) begin tick; n++; end
    nvec++;
    if (a_ovalid !== 1'b1 || a_bit !== 1'b1 || a_oop !== 2'b01) begin
      nmis++; $display("[TB] FAIL midrst_recover got=%b/%b/%0d exp=1/1/1", a_ovalid, a_bit, a_oop);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_ops;
    test_padding;
    test_back_to_back;
    test_backpressure;
    test_reset_midstream;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
